sp_ram_sync: RTL
================

# sp_ram_sync

Parametrised synchronous single-port RAM with byte-enable writes, a post-reset hardware clear sequencer, a ready/valid read handshake and an optional registered output stage. It replaces the fixed 16x8 async scratch RAM in the memory mini-block set and is the standard on-chip buffer for the next designs. One request per cycle once the clear sweep has finished.

## Interface
- DATA_W, 8: data width in bits; must be a multiple of 8, minimum 8
- ADDR_W, 4: address width; DEPTH = 2**ADDR_W words
- OUT_REG, 0: 0 gives a 1-cycle read latency; 1 adds an output register for a 2-cycle latency
- clk  in  1  clock; all logic is on the rising edge
- rst  in  1  reset, synchronous, active-high
- en  in  1  request strobe; a request is accepted when en && ready
- we  in  1  1 = write, 0 = read (sampled with en)
- be  in  DATA_W/8  byte enables for writes; ignored on reads
- addr  in  ADDR_W  word address
- data_in  in  DATA_W  write data
- ready  out  1  high when the RAM accepts requests (state IDLE)
- data_out  out  DATA_W  read data; holds its value until the next accepted read completes
- rd_valid  out  1  single-cycle pulse when data_out carries new read data
- parity_err  out  1  read parity mismatch, qualified by rd_valid; tied 0 without SP_RAM_PARITY_EN

## Operation
- FSM states: CLEAR and IDLE.
- rst forces CLEAR with clr_addr=0. Requests presented in CLEAR are ignored and are not queued.
- In CLEAR, one word is written to zero per cycle at clr_addr, and clr_addr increments. After clr_addr = DEPTH-1 has been written, the FSM goes to IDLE on the next edge. The sweep takes exactly DEPTH cycles.
- In IDLE, ready=1. An accepted write updates byte k of mem[addr] only where be[k]=1. Writes never change data_out or rd_valid.
- An accepted read captures mem[addr] as it was before any same-cycle update. This cannot conflict on a single port.
- With be=0 a write is accepted and changes nothing.
- Back-to-back reads return one result per cycle, in order.
- Addresses need no wrap handling: the full 2**ADDR_W range is valid.

## Timing
- Reset values: ready=0, data_out=0, rd_valid=0, parity_err=0. The pipeline valid bits are cleared.
- Read accepted at edge N: with OUT_REG=0, data_out and rd_valid update at edge N+1; with OUT_REG=1, at edge N+2.
- ready rises DEPTH cycles after the first edge with rst deasserted. For the defaults that is 16 cycles.
- rst asserted mid-sweep restarts the sweep from address 0.
- rst asserted while a read is in flight drops that read: no rd_valid pulse follows.
- rst has priority over every other input.

## Configuration
- SP_RAM_PARITY_EN defined:
  - Each byte is stored with an even-parity bit, computed on write. The clear sweep writes parity 0.
  - On read, parity is recomputed, and parity_err = OR of the per-byte mismatches, aligned with rd_valid.
  - A test-only hierarchical force on the stored parity bit is allowed for verification.
- SP_RAM_PARITY_EN undefined: no parity storage and parity_err is constant 0.

## Structure
- Package sp_ram_pkg holds:
  - the state enum (CLEAR, IDLE)
  - the parity function (per-byte XOR reduce)
  - the localparam helper for byte count (DATA_W/8)
- Sub-module sp_ram_array holds the storage array with byte-enable write and registered read port, with parity bits when enabled.
- The top level holds the FSM, the clear counter, the OUT_REG stage and the valid pipeline.

## Test plan
- Release rst after 1 cycle with defaults: ready=0 for exactly 16 cycles, then 1. A read of every address returns 0x00 with rd_valid one cycle after acceptance.
- DATA_W=32: write addr 3 data 0xAABBCCDD be=4'b1111, then data 0x11223344 be=4'b0101. Read addr 3 returns 0xAA22CC44.
- Reads in consecutive cycles at addresses 1, 2, 3 after writes 0x10, 0x20, 0x30: rd_valid is high for 3 consecutive cycles with data 0x10, 0x20, 0x30. Repeat with OUT_REG=1 and check the extra cycle of latency.
- en=1, we=1, addr 5, data 0xFF during CLEAR: ignored, and a read of addr 5 after ready returns 0x00. Assert rst for one cycle at sweep cycle 8: ready stays low for a further full 16 cycles.
- Read accepted, with rst asserted on the next edge: no rd_valid pulse, data_out=0.
- SP_RAM_PARITY_EN: write 0x5A at addr 7, force the stored parity bit inverted, then read addr 7: data_out=0x5A, rd_valid=1, parity_err=1. An unforced read gives parity_err=0.

Source files
------------

// File: rtl/sp_ram_pkg.sv
// Shared types and helpers for the sp_ram_sync block.
package sp_ram_pkg;

  // Bits per byte lane; the data width is always a whole number of lanes.
  localparam int unsigned BYTE_W = 8;

  // Controller states: CLEAR sweeps the array to zero, IDLE serves requests.
  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

  // Number of byte lanes in a data word.
  function automatic int unsigned bytes_of(input int unsigned data_w);
    return data_w / BYTE_W;
  endfunction

  // Even parity of one byte: the stored bit makes the total count of ones even.
  function automatic logic byte_parity(input logic [BYTE_W-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/sp_ram_array.sv
// Storage array for sp_ram_sync: byte-enable write port and registered read.
// Optional feature macro: SP_RAM_PARITY_EN adds one even-parity bit per byte
// lane and a read-side mismatch flag; without it rpar_err is tied low.
module sp_ram_array
  import sp_ram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic                clk,
  input  logic                we,
  input  logic                re,
  input  logic [DATA_W/8-1:0] be,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata,
  output logic                rpar_err
);

  localparam int NB    = bytes_of(DATA_W);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Byte-lane write; lanes with be low keep their previous contents.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (we && be[b]) begin
        mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Registered read; non-blocking update gives old data on a same-edge write.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

`ifdef SP_RAM_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
  logic [NB-1:0] rpar_q;
  logic [NB-1:0] mism;

  // Parity bits follow the same byte enables as the data lanes.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (we && be[b]) begin
        par_mem[addr][b] <= byte_parity(wdata[b*8 +: 8]);
      end
    end
  end

  // Stored parity is read alongside the data word.
  always_ff @(posedge clk) begin
    if (re) begin
      rpar_q <= par_mem[addr];
    end
  end

  for (genvar gi = 0; gi < NB; gi++) begin : g_par_chk
    assign mism[gi] = byte_parity(rdata_q[gi*8 +: 8]) ^ rpar_q[gi];
  end

  assign rpar_err = |mism;
`else
  assign rpar_err = 1'b0;
`endif

endmodule

// File: rtl/sp_ram_sync.sv
// Synchronous single-port RAM with byte enables, post-reset clear sweep,
// read valid pipeline and optional output register (OUT_REG).
// Optional feature macro: SP_RAM_PARITY_EN (per-byte parity, parity_err).
module sp_ram_sync
  import sp_ram_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int OUT_REG = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   data_in,
  output logic                ready,
  output logic [DATA_W-1:0]   data_out,
  output logic                rd_valid,
  output logic                parity_err
);

  localparam int NB = bytes_of(DATA_W);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;

  logic              arr_we, arr_re;
  logic [NB-1:0]     arr_be;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_wdata, arr_rdata;
  logic              arr_perr;

  // Stage 0: read issued into the array; stage 1: first visible result.
  logic              v0_q, v0_d;
  logic              v1_q, v1_d;
  logic [DATA_W-1:0] data1_q, data1_d;
  logic              perr1_q, perr1_d;

  // State register and clear counter; reset restarts the sweep at word 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // Next state and array port steering; reset blocks all array activity.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    arr_we     = 1'b0;
    arr_re     = 1'b0;
    arr_be     = '0;
    arr_addr   = addr;
    arr_wdata  = data_in;
    case (state_q)
      CLEAR: begin
        arr_we     = 1'b1;
        arr_be     = '1;
        arr_addr   = clr_addr_q;
        arr_wdata  = '0;
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == '1) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (en) begin
          if (we) begin
            arr_we = 1'b1;
            arr_be = be;
          end else begin
            arr_re = 1'b1;
          end
        end
      end
      default: state_d = CLEAR;
    endcase
    if (rst) begin
      arr_we = 1'b0;
      arr_re = 1'b0;
    end
  end

  assign ready = (state_q == IDLE);

  sp_ram_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk      (clk),
    .we       (arr_we),
    .re       (arr_re),
    .be       (arr_be),
    .addr     (arr_addr),
    .wdata    (arr_wdata),
    .rdata    (arr_rdata),
    .rpar_err (arr_perr)
  );

  // Stage-1 next values: capture array data only when a read completes.
  always_comb begin
    v0_d    = arr_re;
    v1_d    = v0_q;
    data1_d = v0_q ? arr_rdata : data1_q;
    perr1_d = v0_q & arr_perr;
  end

  // Valid pipeline and first result register; reset drops in-flight reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
      data1_q <= '0;
      perr1_q <= 1'b0;
    end else begin
      v0_q    <= v0_d;
      v1_q    <= v1_d;
      data1_q <= data1_d;
      perr1_q <= perr1_d;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic              v2_q, v2_d;
    logic [DATA_W-1:0] data2_q, data2_d;
    logic              perr2_q, perr2_d;

    // Extra output stage: same hold-until-next-read behaviour, one cycle later.
    always_comb begin
      v2_d    = v1_q;
      data2_d = v1_q ? data1_q : data2_q;
      perr2_d = v1_q & perr1_q;
    end

    // Output register with synchronous clear.
    always_ff @(posedge clk) begin
      if (rst) begin
        v2_q    <= 1'b0;
        data2_q <= '0;
        perr2_q <= 1'b0;
      end else begin
        v2_q    <= v2_d;
        data2_q <= data2_d;
        perr2_q <= perr2_d;
      end
    end

    assign rd_valid   = v2_q;
    assign data_out   = data2_q;
    assign parity_err = perr2_q;
  end else begin : g_no_out_reg
    assign rd_valid   = v1_q;
    assign data_out   = data1_q;
    assign parity_err = perr1_q;
  end

endmodule
